// File: rtl/test_sink_arb_pkg.sv
// Shared constants and helpers for the round-robin test-sink arbiter.
package test_sink_arb_pkg;

  // Seed and feedback mask for the optional backpressure LFSR (taps 8,6,5,4).
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Tag width for n requesters; a single requester still gets a 1-bit tag.
  function automatic int unsigned id_nbits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/test_sink_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at p_nreqs.
module test_sink_rr_pick
  import test_sink_arb_pkg::*;
#(
  parameter int unsigned p_nreqs = 4,
  localparam int unsigned p_id_nbits = id_nbits(p_nreqs)
) (
  input  logic [p_nreqs-1:0]     reqs,
  input  logic [p_id_nbits-1:0]  ptr,
  output logic [p_nreqs-1:0]     grant,
  output logic [p_id_nbits-1:0]  grant_id
);

  logic                  found;
  logic [p_id_nbits-1:0] idx;

  // Scan from ptr upward; the first active request wins, later ones are masked.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      idx = p_id_nbits'((32'(ptr) + k) % p_nreqs);
      if (!found && reqs[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/test_sink_rr_arbiter.sv
// Round-robin merge of p_nreqs val/rdy streams into one tagged sink stream.
// Output is a 1-entry registered stage; sink_msg = {winner id, payload}.
// Optional macro TEST_SINK_ARB_STALL_EN adds LFSR-driven random backpressure
// on all requesters (the sink side keeps draining).
module test_sink_rr_arbiter
  import test_sink_arb_pkg::*;
#(
  parameter int unsigned p_nreqs     = 4,
  parameter int unsigned p_msg_nbits = 32,
  localparam int unsigned p_id_nbits = id_nbits(p_nreqs)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_nreqs-1:0]               req_val,
  output logic [p_nreqs-1:0]               req_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0]   req_msg,
  output logic                             sink_val,
  input  logic                             sink_rdy,
  output logic [p_id_nbits+p_msg_nbits-1:0] sink_msg,
  output logic [31:0]                      xfer_cnt
);

  logic                              reset_q;
  logic                              full_q;
  logic [p_id_nbits+p_msg_nbits-1:0] msg_q;
  logic [p_id_nbits-1:0]             ptr_q;
  logic [p_id_nbits-1:0]             ptr_d;
  logic [31:0]                       cnt_q;

  logic [p_nreqs-1:0]     grant;
  logic [p_id_nbits-1:0]  grant_id;
  logic [p_msg_nbits-1:0] win_msg;
  logic                   stall;
  logic                   can_accept;
  logic                   drain;
  logic                   fill;

  test_sink_rr_pick #(
    .p_nreqs (p_nreqs)
  ) u_pick (
    .reqs     (req_val),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

`ifdef TEST_SINK_ARB_STALL_EN
  logic [7:0] lfsr_q;

  // Free-running Fibonacci LFSR; bit 0 gates acceptance of new messages.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign drain = full_q && sink_rdy;

  // Requesters stay blocked during reset and the first cycle after it.
  assign can_accept = (!full_q || drain) && !stall && !reset && !reset_q;
  assign req_rdy    = grant & {p_nreqs{can_accept}};
  assign fill       = |(req_val & req_rdy);

  assign ptr_d = (grant_id == p_id_nbits'(p_nreqs - 1)) ? '0 : grant_id + 1'b1;

  // Select the granted requester's payload.
  always_comb begin
    win_msg = '0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      if (grant[i]) win_msg = req_msg[i*p_msg_nbits +: p_msg_nbits];
    end
  end

  // Registered copy of reset used to hold req_rdy low for one extra cycle.
  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // Stage occupancy, priority pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (fill) begin
        full_q <= 1'b1;
        ptr_q  <= ptr_d;
      end else if (drain) begin
        full_q <= 1'b0;
      end
      if (drain) cnt_q <= cnt_q + 32'd1;
    end
  end

  // Stage payload; only meaningful while full_q is set.
  always_ff @(posedge clk) begin
    if (fill) msg_q <= {grant_id, win_msg};
  end

  assign sink_val = full_q;
  assign sink_msg = msg_q;
  assign xfer_cnt = cnt_q;

  a_req_val_known : assert property (@(posedge clk) disable iff (reset) !$isunknown(req_val));
  a_sink_rdy_known : assert property (@(posedge clk) disable iff (reset) !$isunknown(sink_rdy));
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule

// File: tb/tb_test_sink_rr_arbiter.sv
// Bench for test_sink_rr_arbiter: cycle table with hand-derived expectations,
// scoreboard on the sink stream, and a randomized ordering/loss run.
module tb_test_sink_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_val;
  logic [N-1:0]    req_rdy;
  logic [N*W-1:0]  req_msg;
  logic            sink_val;
  logic            sink_rdy;
  logic [W+1:0]    sink_msg;
  logic [31:0]     xfer_cnt;

  test_sink_rr_arbiter #(
    .p_nreqs     (N),
    .p_msg_nbits (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .sink_val (sink_val),
    .sink_rdy (sink_rdy),
    .sink_msg (sink_msg),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  val;
    logic [31:0] base;   // requester i drives base + i
    logic        srdy;
    logic [3:0]  erdy;
    logic        esval;
    logic [33:0] emsg;
    logic [31:0] ecnt;
  } vec_t;

  vec_t        tbl[$];
  logic [33:0] q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] val, input logic [31:0] base,
                              input logic srdy, input logic [3:0] erdy, input logic esval,
                              input logic [1:0] eid, input logic [31:0] epay,
                              input logic [31:0] ecnt);
    vec_t v;
    v.rst   = rst;
    v.val   = val;
    v.base  = base;
    v.srdy  = srdy;
    v.erdy  = erdy;
    v.esval = esval;
    v.emsg  = {eid, epay};
    v.ecnt  = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop and compare on a sink handshake; returns 1 if one happened.
  task automatic sample_sink(output logic popped);
    popped = 1'b0;
    if (sink_val && sink_rdy) begin
      popped = 1'b1;
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %h expected no transfer (t=%0t)", sink_msg, $time);
      end else begin
        check("sb_msg", 64'(sink_msg), 64'(q.pop_front()));
      end
    end
  endtask

  task automatic run_table();
    logic popped;
    // Single requester A0..A3
    tbl.push_back(mk(0, 4'b0010, 32'h9F, 1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 32'h9F, 1, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 32'hA0, 1, 4'b0010, 1, 1, 32'hA0, 0));
    tbl.push_back(mk(0, 4'b0010, 32'hA1, 1, 4'b0010, 1, 1, 32'hA1, 1));
    tbl.push_back(mk(0, 4'b0010, 32'hA2, 1, 4'b0010, 1, 1, 32'hA2, 2));
    tbl.push_back(mk(0, 4'b0000, 32'h0,  1, 4'b0000, 1, 1, 32'hA3, 3));
    tbl.push_back(mk(0, 4'b0000, 32'h0,  1, 4'b0000, 0, 0, 0, 4));
    // Reset, then all four always valid
    tbl.push_back(mk(1, 4'b0000, 32'h0,  0, 4'b0000, 0, 0, 0, 4));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0100, 1, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b1000, 1, 2, 2, 2));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0001, 1, 3, 3, 3));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0010, 1, 0, 0, 4));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b0100, 1, 1, 1, 5));
    tbl.push_back(mk(0, 4'b1111, 32'h0,  1, 4'b1000, 1, 2, 2, 6));
    tbl.push_back(mk(0, 4'b0000, 32'h0,  1, 4'b0000, 1, 3, 3, 7));
    tbl.push_back(mk(0, 4'b0000, 32'h0,  1, 4'b0000, 0, 0, 0, 8));
    // Backpressure: fill, hold 5 cycles, then drain and refill together
    tbl.push_back(mk(0, 4'b0001, 32'h100, 0, 4'b0001, 0, 0, 0, 8));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'b0001, 32'h200, 0, 4'b0000, 1, 0, 32'h100, 8));
    tbl.push_back(mk(0, 4'b0001, 32'h200, 1, 4'b0001, 1, 0, 32'h100, 8));
    tbl.push_back(mk(0, 4'b0000, 32'h0,   1, 4'b0000, 1, 0, 32'h200, 9));
    tbl.push_back(mk(0, 4'b0000, 32'h0,   1, 4'b0000, 0, 0, 0, 10));
    // Reset with {2, DEAD} buffered
    tbl.push_back(mk(0, 4'b0100, 32'hDEAB, 0, 4'b0100, 0, 0, 0, 10));
    tbl.push_back(mk(1, 4'b0000, 32'h0,    0, 4'b0000, 1, 2, 32'hDEAD, 10));
    tbl.push_back(mk(0, 4'b0000, 32'h0,    1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 32'h2FD,  1, 4'b1000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h0,    1, 4'b0000, 1, 3, 32'h300, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h0,    1, 4'b0000, 0, 0, 0, 1));

    foreach (tbl[r]) begin
      @(negedge clk);
      reset    = tbl[r].rst;
      req_val  = tbl[r].val;
      sink_rdy = tbl[r].srdy;
      for (int i = 0; i < N; i++) req_msg[i*W +: W] = tbl[r].base + 32'(i);
      #1;
      check($sformatf("row%0d_req_rdy", r), 64'(req_rdy), 64'(tbl[r].erdy));
      check($sformatf("row%0d_sink_val", r), 64'(sink_val), 64'(tbl[r].esval));
      check($sformatf("row%0d_xfer_cnt", r), 64'(xfer_cnt), 64'(tbl[r].ecnt));
      if (tbl[r].esval) check($sformatf("row%0d_sink_msg", r), 64'(sink_msg), 64'(tbl[r].emsg));
      sample_sink(popped);
      for (int i = 0; i < N; i++)
        if (tbl[r].erdy[i]) q.push_back({2'(i), tbl[r].base + 32'(i)});
      if (tbl[r].rst) q.delete();
    end
    check("tbl_sb_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic run_random(input int n);
    int          launched;
    int          rx;
    int unsigned seq[N];
    logic [31:0] cur[N];
    logic [N-1:0] acc;
    logic        popped;
    launched = 0;
    rx       = 0;
    acc      = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      cur[i] = '0;
    end
    @(negedge clk);
    reset    = 1'b1;
    req_val  = '0;
    sink_rdy = 1'b0;
    q.delete();
    @(negedge clk);
    reset   = 1'b0;
    req_val = '1;
    #1;
    check("post_reset_req_rdy", 64'(req_rdy), 64'd0);
    check("post_reset_sink_val", 64'(sink_val), 64'd0);
    check("post_reset_xfer_cnt", 64'(xfer_cnt), 64'd0);
    @(negedge clk);
    req_val = '0;
    for (int cyc = 0; cyc < 20000 && rx < n; cyc++) begin
      @(negedge clk);
      req_val = req_val & ~acc;
      acc     = '0;
      for (int i = 0; i < N; i++) begin
        if (!req_val[i] && launched < n && $urandom_range(0, 2) != 0) begin
          cur[i]  = {8'(i), 24'(seq[i])};
          seq[i]++;
          launched++;
          req_val[i] = 1'b1;
          req_msg[i*W +: W] = cur[i];
        end
      end
      sink_rdy = ($urandom_range(0, 3) != 0);
      #1;
      check("rand_rdy_onehot0", 64'($onehot0(req_rdy)), 64'd1);
      sample_sink(popped);
      if (popped) rx++;
      for (int i = 0; i < N; i++) begin
        if (req_val[i] && req_rdy[i]) begin
          q.push_back({2'(i), cur[i]});
          acc[i] = 1'b1;
        end
      end
    end
    check("rand_rx_count", 64'(rx), 64'(n));
    @(negedge clk);
    req_val  = '0;
    sink_rdy = 1'b0;
    #1;
    check("rand_xfer_cnt", 64'(xfer_cnt), 64'(n));
    check("rand_sb_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req_val  = '0;
    req_msg  = '0;
    sink_rdy = 1'b0;
    repeat (2) @(posedge clk);
`ifdef TEST_SINK_ARB_STALL_EN
    run_random(1000);
`else
    run_table();
    run_random(300);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
